// File: rtl/bip_data_memory_pkg.sv
// Shared constants and FSM encoding for the BIP data memory.
package bip_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 11;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } dmem_state_t;

  // Index width needed to address `depth` words; never below one bit.
  function automatic int addr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/bip_data_memory_if.sv
// CPU data-port bundle: Rd/Wr strobes, word address, write data and read data.
// The CPU (master) drives strobes, address and write data; the memory (slave)
// returns Out_Data combinationally in the same cycle Rd is asserted.
interface bip_data_memory_if #(
  parameter int ADDR_W = bip_pkg::ADDR_W,
  parameter int DATA_W = bip_pkg::DATA_W
) ();

  logic              Rd;
  logic              Wr;
  logic [ADDR_W-1:0] DataAddr;
  logic [DATA_W-1:0] In_Data;
  logic [DATA_W-1:0] Out_Data;

  modport master (
    output Rd,
    output Wr,
    output DataAddr,
    output In_Data,
    input  Out_Data
  );

  modport slave (
    input  Rd,
    input  Wr,
    input  DataAddr,
    input  In_Data,
    output Out_Data
  );

endinterface

// File: rtl/bip_data_memory_array.sv
// Plain word storage: one synchronous write port, one asynchronous read port.
// No reset; contents are initialised by the clear sweep in the top level.
module bip_dmem_array #(
  parameter int DATA_W = 16,
  parameter int AW     = 11,
  parameter int DEPTH  = 2048
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/bip_data_memory.sv
// BIP CPU data memory: zero-fill sweep after reset, then combinational reads and
// edge-committed writes with a sticky error flag. Define BIP_DMEM_STATS_EN for access counters.
module bip_data_memory #(
  parameter int DATA_W = bip_pkg::DATA_W,
  parameter int ADDR_W = bip_pkg::ADDR_W,
  parameter int DEPTH  = 2048
) (
  input  logic                 Clock,
  input  logic                 Reset,
  bip_data_memory_if.slave     bus,
  input  logic                 ErrClr,
  output logic                 Ready,
  output logic                 Err,
  output bip_pkg::dmem_state_t state
`ifdef BIP_DMEM_STATS_EN
  ,
  output logic [15:0]          RdCount,
  output logic [15:0]          WrCount
`endif
);

  import bip_pkg::*;

  localparam int AW = addr_bits(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  logic [AW-1:0]     clr_ptr;
  logic              clearing;
  logic              in_range;
  logic              rd_ok;
  logic              wr_ok;
  logic              err_set;
  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  assign clearing = (state == CLEAR);
  assign in_range = (32'(bus.DataAddr) < 32'(DEPTH));

  // A read always wins over a simultaneous write, so the write needs Rd low.
  assign rd_ok   = !clearing && bus.Rd && in_range;
  assign wr_ok   = !clearing && bus.Wr && !bus.Rd && in_range;
  assign err_set = !clearing &&
                   ((bus.Rd && bus.Wr) || ((bus.Rd || bus.Wr) && !in_range));

  // Sweep zero-writes own the write port until the array is clean.
  assign mem_we    = clearing || wr_ok;
  assign mem_waddr = clearing ? clr_ptr : bus.DataAddr[AW-1:0];
  assign mem_wdata = clearing ? '0 : bus.In_Data;

  assign bus.Out_Data = rd_ok ? mem_rdata : '0;

  bip_dmem_array #(
    .DATA_W (DATA_W),
    .AW     (AW),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (Clock),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (bus.DataAddr[AW-1:0]),
    .rdata (mem_rdata)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state   <= CLEAR;
      clr_ptr <= '0;
      Ready   <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (clr_ptr == LAST_ADDR) begin
            state <= READY;
            Ready <= 1'b1;
          end
        end
        READY: begin
          Ready <= 1'b1;
        end
        default: begin
          state <= CLEAR;
          Ready <= 1'b0;
        end
      endcase
    end
  end

  // Setting beats clearing when both happen in the same cycle.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      Err <= 1'b0;
    end else if (err_set) begin
      Err <= 1'b1;
    end else if (ErrClr) begin
      Err <= 1'b0;
    end
  end

`ifdef BIP_DMEM_STATS_EN
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      RdCount <= '0;
      WrCount <= '0;
    end else begin
      if (rd_ok && (RdCount != 16'hFFFF)) begin
        RdCount <= RdCount + 16'd1;
      end
      if (wr_ok && (WrCount != 16'hFFFF)) begin
        WrCount <= WrCount + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_bip_data_memory.sv
// Directed bench for bip_data_memory at DEPTH=8: sweep timing, read/write path,
// error flag behaviour, resets mid-sweep and mid-operation, optional counters.
module tb_bip_data_memory;

  import bip_pkg::*;

  localparam int DEPTH = 8;
  localparam int AW    = bip_pkg::ADDR_W;
  localparam int DW    = bip_pkg::DATA_W;

  logic        Clock  = 1'b0;
  logic        Reset  = 1'b0;
  logic        ErrClr = 1'b0;
  logic        Ready;
  logic        Err;
  dmem_state_t state;
`ifdef BIP_DMEM_STATS_EN
  logic [15:0] RdCount;
  logic [15:0] WrCount;
`endif

  bip_data_memory_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  bip_data_memory #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .DEPTH  (DEPTH)
  ) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .bus     (bus),
    .ErrClr  (ErrClr),
    .Ready   (Ready),
    .Err     (Err),
    .state   (state)
`ifdef BIP_DMEM_STATS_EN
    ,
    .RdCount (RdCount),
    .WrCount (WrCount)
`endif
  );

  // Clock / reset block
  always #5 Clock = ~Clock;

  int            checks   = 0;
  int            failures = 0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] model [DEPTH];
  int            rd_exp   = 0;
  int            wr_exp   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge Clock);
    #1;
  endtask

  // Driver tasks: called just after a rising edge, return just after the next one.
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.Rd       = 1'b0;
    bus.Wr       = 1'b1;
    bus.DataAddr = a;
    bus.In_Data  = d;
    cycle();
    bus.Wr = 1'b0;
    if (32'(a) < DEPTH) begin
      model[a[2:0]] = d;
      wr_exp++;
    end
  endtask

  task automatic do_read(input logic [AW-1:0] a, input string tag);
    bus.Rd       = 1'b1;
    bus.Wr       = 1'b0;
    bus.DataAddr = a;
    exp_q.push_back((32'(a) < DEPTH) ? model[a[2:0]] : '0);
    #1;
    check(tag, 32'(bus.Out_Data), 32'(exp_q.pop_front()));
    if (32'(a) < DEPTH) rd_exp++;
    cycle();
    bus.Rd = 1'b0;
  endtask

  // Ready must stay low for DEPTH-1 edges after release and rise on edge DEPTH.
  task automatic wait_sweep(input string tag);
    for (int i = 1; i <= DEPTH; i++) begin
      cycle();
      check(tag, 32'(Ready), (i == DEPTH) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  initial begin
    logic [DW-1:0] acc;
    logic [AW-1:0] ra;
    bus.Rd = 1'b0;
    bus.Wr = 1'b0;
    bus.DataAddr = '0;
    bus.In_Data = '0;
    clear_model();

    // Power-on reset held for two cycles
    cycle();
    cycle();
    check("rst_ready", 32'(Ready), 32'd0);
    check("rst_err", 32'(Err), 32'd0);
    check("rst_state", 32'(state), 32'(CLEAR));

    // Release; a CPU write held across the sweep must be ignored
    Reset = 1'b1;
    bus.Wr = 1'b1;
    bus.DataAddr = '0;
    bus.In_Data = 16'hFFFF;
    wait_sweep("sweep_ready");
    bus.Wr = 1'b0;
    check("sweep_err", 32'(Err), 32'd0);
    check("sweep_state", 32'(state), 32'(READY));
    for (int i = 0; i < DEPTH; i++) do_read(AW'(i), "zero_fill");

    // Write then same-cycle read, then idle read port
    do_write(AW'(5), 16'h00A5);
    do_read(AW'(5), "rd_after_wr");
    #1;
    check("rd_idle_zero", 32'(bus.Out_Data), 32'd0);

    // LDi 1; ADDi 1; STO 0
    acc = 16'd1;
    acc = acc + 16'd1;
    do_write(AW'(0), acc);
    do_read(AW'(0), "prog_sto");
    check("prog_err", 32'(Err), 32'd0);

    // Rd and Wr together: read wins, write dropped, Err set
    do_write(AW'(3), 16'h0007);
    bus.Rd = 1'b1;
    bus.Wr = 1'b1;
    bus.DataAddr = AW'(3);
    bus.In_Data = 16'h1234;
    exp_q.push_back(model[3]);
    #1;
    check("rdwr_out", 32'(bus.Out_Data), 32'(exp_q.pop_front()));
    rd_exp++;
    cycle();
    bus.Rd = 1'b0;
    bus.Wr = 1'b0;
    check("rdwr_err", 32'(Err), 32'd1);
    do_read(AW'(3), "rdwr_keep");
    ErrClr = 1'b1;
    cycle();
    ErrClr = 1'b0;
    check("errclr", 32'(Err), 32'd0);

    // Set condition coincident with ErrClr: set wins
    bus.Rd = 1'b1;
    bus.Wr = 1'b1;
    bus.DataAddr = AW'(3);
    ErrClr = 1'b1;
    rd_exp++;
    cycle();
    bus.Rd = 1'b0;
    bus.Wr = 1'b0;
    ErrClr = 1'b0;
    check("set_beats_clr", 32'(Err), 32'd1);
    ErrClr = 1'b1;
    cycle();
    ErrClr = 1'b0;

    // Out-of-range write (aliases to word 1 if the range check is broken)
    do_write(AW'(1), 16'hBEEF);
    do_write(AW'(9), 16'h5A5A);
    check("oor_wr_err", 32'(Err), 32'd1);
    do_read(AW'(1), "oor_wr_keep");
    ErrClr = 1'b1;
    cycle();
    ErrClr = 1'b0;
    do_read(AW'(9), "oor_rd_zero");
    check("oor_rd_err", 32'(Err), 32'd1);
    ErrClr = 1'b1;
    cycle();
    ErrClr = 1'b0;

    // Random in-range traffic
    for (int i = 0; i < 6; i++) begin
      ra = AW'($urandom_range(0, DEPTH - 1));
      do_write(ra, DW'($urandom_range(0, 16'hFFFF)));
    end
    for (int i = 0; i < DEPTH; i++) do_read(AW'(i), "rand_rd");
    check("rand_err", 32'(Err), 32'd0);

`ifdef BIP_DMEM_STATS_EN
    check("rd_count", 32'(RdCount), 32'(rd_exp));
    check("wr_count", 32'(WrCount), 32'(wr_exp));
`endif

    // Reset mid-operation with Err set
    do_write(AW'(12), 16'h0001);
    Reset = 1'b0;
    #1;
    check("midop_ready", 32'(Ready), 32'd0);
    check("midop_err", 32'(Err), 32'd0);
    check("midop_state", 32'(state), 32'(CLEAR));
`ifdef BIP_DMEM_STATS_EN
    check("midop_rdcnt", 32'(RdCount), 32'd0);
    check("midop_wrcnt", 32'(WrCount), 32'd0);
`endif
    cycle();
    Reset = 1'b1;
    bus.Rd = 1'b1;
    bus.DataAddr = AW'(5);
    for (int i = 0; i < 4; i++) cycle();
    check("clear_rd_zero", 32'(bus.Out_Data), 32'd0);

    // Reset at sweep cycle 4 restarts the full sweep
    Reset = 1'b0;
    #1;
    check("midsweep_ready", 32'(Ready), 32'd0);
    cycle();
    Reset = 1'b1;
    wait_sweep("resweep_ready");
    bus.Rd = 1'b0;
    check("resweep_err", 32'(Err), 32'd0);
    clear_model();
    for (int i = 0; i < DEPTH; i++) do_read(AW'(i), "resweep_zero");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
